// File: rtl/imm_packer.sv
// imm_packer: inserts a 32-bit immediate into the immediate field(s) of an
// instruction word and flags values the selected format cannot represent.
// Two-stage valid/ready pipeline: S1 slices and range-checks, S2 merges.
// Optional feature macro: IMM_ERR_CNT_EN (saturating count of delivered errors).
module imm_packer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_imm,
  input  logic [5:0]       in_extop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             err_cnt_clr
);

  // One-hot format codes shared with the immediate extender.
  localparam logic [5:0] EXT_ITYPE_SHAMT = 6'b100000;
  localparam logic [5:0] EXT_ITYPE       = 6'b010000;
  localparam logic [5:0] EXT_STYPE       = 6'b001000;
  localparam logic [5:0] EXT_BTYPE       = 6'b000100;
  localparam logic [5:0] EXT_UTYPE       = 6'b000010;
  localparam logic [5:0] EXT_JTYPE       = 6'b000001;

  logic        s1_valid;
  logic [31:0] s1_instr;
  logic [5:0]  s1_extop;
  logic [31:0] s1_field;
  logic        s1_ok;
  logic        s2_valid;

  logic        s1_adv;
  logic        s2_adv;
  logic [31:0] field_d;
  logic        ok_d;
  logic [31:0] mask;
  logic [31:0] merged;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  // S1 combinational: place immediate bits at their instruction positions and range-check.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    field_d = '0;
    ok_d    = 1'b0;
    unique case (in_extop)
      EXT_ITYPE_SHAMT: begin
        field_d = {7'b0, in_imm[4:0], 20'b0};
        ok_d    = (in_imm[31:5] == '0);
      end
      EXT_ITYPE: begin
        field_d = {in_imm[11:0], 20'b0};
        ok_d    = (in_imm[31:11] == '0) || (&in_imm[31:11]);
      end
      EXT_STYPE: begin
        field_d = {in_imm[11:5], 13'b0, in_imm[4:0], 7'b0};
        ok_d    = (in_imm[31:11] == '0) || (&in_imm[31:11]);
      end
      EXT_BTYPE: begin
        field_d = {in_imm[12], in_imm[10:5], 13'b0, in_imm[4:1], in_imm[11], 7'b0};
        ok_d    = !in_imm[0] && ((in_imm[31:12] == '0) || (&in_imm[31:12]));
      end
      EXT_UTYPE: begin
        field_d = {in_imm[31:12], 12'b0};
        ok_d    = (in_imm[11:0] == '0);
      end
      EXT_JTYPE: begin
        field_d = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], 12'b0};
        ok_d    = !in_imm[0] && ((in_imm[31:20] == '0) || (&in_imm[31:20]));
      end
      default: begin
        field_d = '0;
        ok_d    = 1'b0;
      end
    endcase
  end

  // S1 occupancy flag.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
    end
  end

  // S1 payload capture on accept.
  always_ff @(posedge clk) begin
    // NOTE: payload flops carry no reset; they are only observed behind s1_valid.
    if (s1_adv && in_valid) begin
      s1_instr <= in_instr;
      s1_extop <= in_extop;
      s1_field <= field_d;
      s1_ok    <= ok_d;
    end
  end

  // S2 combinational: decode the field mask and merge, or pass the template through on error.
  always_comb begin
    mask = '0;
    unique case (s1_extop)
      EXT_ITYPE_SHAMT: mask = 32'h01F0_0000;
      EXT_ITYPE:       mask = 32'hFFF0_0000;
      EXT_STYPE:       mask = 32'hFE00_0F80;
      EXT_BTYPE:       mask = 32'hFE00_0F80;
      EXT_UTYPE:       mask = 32'hFFFF_F000;
      EXT_JTYPE:       mask = 32'hFFFF_F000;
      default:         mask = '0;
    endcase
    merged = s1_ok ? ((s1_instr & ~mask) | s1_field) : s1_instr;
  end

  // S2 output register; holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      out_instr <= '0;
      out_err   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_instr <= merged;
        out_err   <= !s1_ok;
      end
    end
  end

`ifdef IMM_ERR_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Saturating count of delivered error results; clear has priority over increment.
  always_ff @(posedge clk) begin
    if (rst || err_cnt_clr) begin
      cnt_q <= '0;
    end else if (out_valid && out_ready && out_err && (cnt_q != '1)) begin
      cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign err_cnt = cnt_q;
`else
  logic unused_clr;
  assign unused_clr = err_cnt_clr;
  assign err_cnt    = '0;
`endif

endmodule
